// File: rtl/life_cell_gen.sv
// Single Game-of-Life cell with configurable birth/survive rules, stability and change tracking.
// Optional age counter is built only when LIFE_CELL_AGE_EN is defined; otherwise age reads 0.
module life_cell_gen #(
    parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0] SURVIVE_MASK = 9'b000001100,
    parameter int         AGE_W        = 8,
    parameter int         STABLE_GENS  = 4,
    localparam int        STABLE_W     = $clog2(STABLE_GENS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             state_0,
    input  logic [7:0]       neighbors,
    output logic             state_d,
    output logic             state_q,
    output logic [3:0]       count,
    output logic [AGE_W-1:0] age,
    output logic             stable,
    output logic             changed
);

    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(STABLE_GENS);

    logic [STABLE_W-1:0] stable_cnt;
    logic                same_next;

    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, neighbors[i]};
        end
    end

    assign state_d   = state_q ? SURVIVE_MASK[count] : BIRTH_MASK[count];
    assign same_next = (state_d == state_q);

    // Reset takes priority over a step, so rst+ena together behaves as a plain reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= state_0;
            stable_cnt <= '0;
            changed    <= 1'b0;
        end else begin
            changed <= ena && !same_next;
            if (ena) begin
                state_q <= state_d;
                if (!same_next) begin
                    stable_cnt <= '0;
                end else if (stable_cnt != STABLE_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end
    end

    assign stable = (stable_cnt == STABLE_MAX);

`ifdef LIFE_CELL_AGE_EN
    logic [AGE_W-1:0] age_q;

    // Age counts generations survived; any birth, death or dead-stays-dead step clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
        end else if (ena) begin
            if (state_q && state_d) begin
                if (age_q != {AGE_W{1'b1}}) begin
                    age_q <= age_q + 1'b1;
                end
            end else begin
                age_q <= '0;
            end
        end
    end

    assign age = age_q;
`else
    assign age = '0;
`endif

endmodule
